// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit FSM between NUM_REQ requesters.
// Snapshots byte and frame config, launches, retries on error/timeout, then acks or nacks.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MAX_RETRY   = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [3:0]           cfg_data_len,
   input  logic                 cfg_parity_en,
   input  logic                 cfg_stop2,
   input  logic                 tx_done,
   input  logic                 tx_error,
   output logic                 tx_en,
   output logic [7:0]           tx_data,
   output logic [3:0]           tx_data_len,
   output logic                 tx_parity_mode,
   output logic                 tx_stop_twice,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [2:0]           grant_id,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   nack,
   output logic                 busy
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMPLETE} state_t;

   state_t         state, next_state;
   logic [2:0]     ptr;
   logic [RW-1:0]  retry_cnt;
   logic [TW-1:0]  timer;

   logic           win_valid;
   logic [2:0]     win_id;
   logic [7:0]     win_data;
   logic           fail;
   logic           success;
   logic           retry_ok;

   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      if (len < 4'd5)      return 4'd5;
      else if (len > 4'd8) return 4'd8;
      else                 return len;
   endfunction

   // Search upward from the pointer; the inner loop keeps every bit select constant.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
      win_valid = 1'b0;
      win_id    = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int cand;
         cand = int'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_valid && j == cand && req[j]) begin
               win_valid = 1'b1;
               win_id    = 3'(j);
               win_data  = req_data[j*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      fail       = 1'b0;
      success    = 1'b0;
      retry_ok   = int'(retry_cnt) < MAX_RETRY;
      case (state)
         S_IDLE:     if (win_valid) next_state = S_LAUNCH;
         S_LAUNCH:   next_state = S_WAIT;
         S_WAIT: begin
            // Error has priority over a simultaneous done.
            if (tx_error || timer == TW'(TIMEOUT_CYC - 1)) begin
               fail       = 1'b1;
               next_state = retry_ok ? S_LAUNCH : S_COMPLETE;
            end else if (tx_done) begin
               success    = 1'b1;
               next_state = S_COMPLETE;
            end
         end
         S_COMPLETE: next_state = S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tx_en          <= 1'b0;
         tx_data        <= '0;
         tx_data_len    <= 4'd8;
         tx_parity_mode <= 1'b0;
         tx_stop_twice  <= 1'b0;
         gnt            <= '0;
         grant_id       <= '0;
         ack            <= '0;
         nack           <= '0;
         ptr            <= '0;
         retry_cnt      <= '0;
         timer          <= '0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
         tx_en <= (state == S_LAUNCH);
         ack   <= '0;
         nack  <= '0;
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  gnt            <= NUM_REQ'(1) << win_id;
                  grant_id       <= win_id;
                  tx_data        <= win_data;
                  tx_data_len    <= clamp_len(cfg_data_len);
                  tx_parity_mode <= cfg_parity_en;
                  tx_stop_twice  <= cfg_stop2;
                  retry_cnt      <= '0;
               end
            end
            S_LAUNCH: timer <= '0;
            S_WAIT: begin
               timer <= timer + TW'(1);
               if (fail) begin
                  if (retry_ok) retry_cnt <= retry_cnt + RW'(1);
                  else          nack      <= gnt;
               end else if (success) begin
                  ack <= gnt;
               end
            end
            S_COMPLETE: begin
               gnt <= '0;
               ptr <= (int'(grant_id) == NUM_REQ - 1) ? 3'd0 : grant_id + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one default instance plus one with a 16-cycle
// timeout, both driven by the same stimulus; each check is an immediate assertion.
module tb_uart_tx_arbiter;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  cfg_data_len = 4'd8;
   logic        cfg_parity_en = 1'b0;
   logic        cfg_stop2 = 1'b0;
   logic        tx_done = 1'b0;
   logic        tx_error = 1'b0;

   logic        s_tx_en, s_parity, s_stop2, s_busy;
   logic [7:0]  s_tx_data;
   logic [3:0]  s_len, s_gnt, s_ack, s_nack;
   logic [2:0]  s_gid;

   logic        f_tx_en, f_parity, f_stop2, f_busy;
   logic [7:0]  f_tx_data;
   logic [3:0]  f_len, f_gnt, f_ack, f_nack;
   logic [2:0]  f_gid;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arbiter u_dut (
      .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_data(req_data),
      .cfg_data_len(cfg_data_len), .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2),
      .tx_done(tx_done), .tx_error(tx_error),
      .tx_en(s_tx_en), .tx_data(s_tx_data), .tx_data_len(s_len),
      .tx_parity_mode(s_parity), .tx_stop_twice(s_stop2),
      .gnt(s_gnt), .grant_id(s_gid), .ack(s_ack), .nack(s_nack), .busy(s_busy)
   );

   uart_tx_arbiter #(.TIMEOUT_CYC(16)) u_fast (
      .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_data(req_data),
      .cfg_data_len(cfg_data_len), .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2),
      .tx_done(tx_done), .tx_error(tx_error),
      .tx_en(f_tx_en), .tx_data(f_tx_data), .tx_data_len(f_len),
      .tx_parity_mode(f_parity), .tx_stop_twice(f_stop2),
      .gnt(f_gnt), .grant_id(f_gid), .ack(f_ack), .nack(f_nack), .busy(f_busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] bytes2 [4];
      logic [3:0] exp_g;
      int n;
      int ack_seen;
      bytes2 = '{8'h11, 8'h22, 8'h33, 8'h44};

      // Reset state
      tick(2);
      check("rst_gnt",    32'(s_gnt),     32'(4'b0000));
      check("rst_busy",   32'(s_busy),    32'(1'b0));
      check("rst_txen",   32'(s_tx_en),   32'(1'b0));
      check("rst_len",    32'(s_len),     32'(4'd8));
      check("rst_data",   32'(s_tx_data), 32'(8'h00));
      check("rst_ack",    32'(s_ack | s_nack), 32'(4'b0000));
      PRESET = 1'b0;
      tick(1);

      // 1: single request, acked after ~20 cycles
      req = 4'b0001;
      req_data = 32'h0000_00A5;
      tick(1);
      check("t1_gnt",    32'(s_gnt),     32'(4'b0001));
      check("t1_data",   32'(s_tx_data), 32'(8'hA5));
      check("t1_len",    32'(s_len),     32'(4'd8));
      check("t1_txen0",  32'(s_tx_en),   32'(1'b0));
      check("t1_busy",   32'(s_busy),    32'(1'b1));
      tick(1);
      check("t1_txen",   32'(s_tx_en),   32'(1'b1));
      tick(1);
      check("t1_txen_off", 32'(s_tx_en), 32'(1'b0));
      tick(17);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      check("t1_ack",    32'(s_ack),     32'(4'b0001));
      check("t1_nack",   32'(s_nack),    32'(4'b0000));
      req = 4'b0000;
      tick(1);
      check("t1_ack_off",  32'(s_ack),  32'(4'b0000));
      check("t1_busy_off", 32'(s_busy), 32'(1'b0));
      check("t1_gnt_off",  32'(s_gnt),  32'(4'b0000));

      // 2: all four requesting; reset first so the pointer starts at 0
      PRESET = 1'b1;
      tick(1);
      PRESET = 1'b0;
      req = 4'b1111;
      req_data = 32'h4433_2211;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'(1 << (k % 4));
         tick(1);
         check("t2_gid",  32'(s_gid),     32'(k % 4));
         check("t2_gnt",  32'(s_gnt),     32'(exp_g));
         check("t2_data", 32'(s_tx_data), 32'(bytes2[k % 4]));
         tick(1);
         tx_done = 1'b1;
         tick(1);
         tx_done = 1'b0;
         check("t2_ack",  32'(s_ack),     32'(exp_g));
         if (k == 4) req = 4'b0000;
         tick(1);
      end
      check("t2_idle", 32'(s_busy), 32'(1'b0));

      // 3: three errors in a row -> nack; pointer is now 1
      req = 4'b0010;
      req_data = 32'h0000_5C00;
      tick(1);
      check("t3_gnt",  32'(s_gnt),     32'(4'b0010));
      check("t3_data", 32'(s_tx_data), 32'(8'h5C));
      req_data = 32'hFFFF_FFFF;
      for (int a = 0; a < 3; a++) begin
         tick(1);
         check("t3_txen",      32'(s_tx_en),   32'(1'b1));
         check("t3_data_hold", 32'(s_tx_data), 32'(8'h5C));
         tx_error = 1'b1;
         tick(1);
         tx_error = 1'b0;
         check("t3_ack", 32'(s_ack), 32'(4'b0000));
         if (a < 2) check("t3_nack_early", 32'(s_nack), 32'(4'b0000));
         else       check("t3_nack",       32'(s_nack), 32'(4'b0010));
      end
      req = 4'b0000;
      tick(1);
      check("t3_nack_off", 32'(s_nack), 32'(4'b0000));
      check("t3_idle",     32'(s_busy), 32'(1'b0));

      // 6: reset mid-WAIT with requester 2 granted (pointer 2)
      req = 4'b0100;
      req_data = 32'h00C3_0000;
      cfg_data_len = 4'd6;
      cfg_parity_en = 1'b1;
      cfg_stop2 = 1'b1;
      tick(1);
      check("t6_gnt",    32'(s_gnt),     32'(4'b0100));
      check("t6_data",   32'(s_tx_data), 32'(8'hC3));
      check("t6_len",    32'(s_len),     32'(4'd6));
      check("t6_par",    32'(s_parity),  32'(1'b1));
      check("t6_stop",   32'(s_stop2),   32'(1'b1));
      tick(4);
      check("t6_busy",   32'(s_busy),    32'(1'b1));
      #2;
      PRESET = 1'b1;
      #1;
      check("t6_r_gnt",  32'(s_gnt),     32'(4'b0000));
      check("t6_r_busy", 32'(s_busy),    32'(1'b0));
      check("t6_r_gid",  32'(s_gid),     32'(3'd0));
      check("t6_r_data", 32'(s_tx_data), 32'(8'h00));
      check("t6_r_len",  32'(s_len),     32'(4'd8));
      check("t6_r_par",  32'(s_parity),  32'(1'b0));
      check("t6_r_stop", 32'(s_stop2),   32'(1'b0));
      check("t6_r_txen", 32'(s_tx_en),   32'(1'b0));
      tick(1);
      cfg_data_len = 4'd8;
      cfg_parity_en = 1'b0;
      cfg_stop2 = 1'b0;
      PRESET = 1'b0;
      req = 4'b0110;
      req_data = 32'h00C3_7E00;
      tick(1);
      // pointer back at 0, so requester 1 wins over 2
      check("t6_gid",    32'(s_gid),     32'(3'd1));
      check("t6_gnt2",   32'(s_gnt),     32'(4'b0010));
      check("t6_data2",  32'(s_tx_data), 32'(8'h7E));
      tick(1);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      check("t6_ack",    32'(s_ack),     32'(4'b0010));
      req = 4'b0000;
      tick(1);

      // 5: done+error together counts as error; length clamping (pointer now 2)
      req = 4'b0100;
      req_data = 32'h00AA_0000;
      cfg_data_len = 4'd3;
      tick(1);
      check("t5_gnt",    32'(s_gnt),     32'(4'b0100));
      check("t5_len_lo", 32'(s_len),     32'(4'd5));
      cfg_data_len = 4'd12;
      tick(1);
      tx_done = 1'b1;
      tx_error = 1'b1;
      tick(1);
      tx_done = 1'b0;
      tx_error = 1'b0;
      check("t5_both_ack",  32'(s_ack),  32'(4'b0000));
      check("t5_both_nack", 32'(s_nack), 32'(4'b0000));
      tick(1);
      check("t5_relaunch",  32'(s_tx_en), 32'(1'b1));
      check("t5_len_hold",  32'(s_len),   32'(4'd5));
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      check("t5_ack",    32'(s_ack),     32'(4'b0100));
      req = 4'b0000;
      tick(1);
      req = 4'b1000;
      req_data = 32'hBB00_0000;
      tick(1);
      check("t5_gid",    32'(s_gid),     32'(3'd3));
      check("t5_len_hi", 32'(s_len),     32'(4'd8));
      tick(1);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      check("t5_ack3",   32'(s_ack),     32'(4'b1000));
      req = 4'b0000;
      tick(1);

      // 4: silent tx FSM on the 16-cycle-timeout instance
      PRESET = 1'b1;
      tick(1);
      PRESET = 1'b0;
      req = 4'b0001;
      req_data = 32'h0000_003C;
      ack_seen = 0;
      tick(2);
      check("t4_txen", 32'(f_tx_en), 32'(1'b1));
      // 16 WAIT cycles then the LAUNCH cycle separate consecutive tx_en pulses
      for (int g = 0; g < 2; g++) begin
         n = 0;
         do begin
            tick(1);
            n++;
            if (f_ack != 4'b0000 || f_nack != 4'b0000) ack_seen++;
         end while (f_tx_en !== 1'b1 && n < 40);
         check("t4_gap", 32'(n), 32'(17));
      end
      n = 0;
      do begin
         tick(1);
         n++;
         if (f_ack != 4'b0000) ack_seen++;
      end while (f_nack == 4'b0000 && n < 40);
      check("t4_nack_lat", 32'(n),      32'(16));
      check("t4_nack",     32'(f_nack), 32'(4'b0001));
      check("t4_no_ack",   32'(ack_seen), 32'(0));
      req = 4'b0000;
      tick(2);
      check("t4_idle",     32'(f_busy), 32'(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
